// File: rtl/tpu_output_collector.sv
// De-skews the per-column result stream leaving the bottom PE row and assembles
// an N x N matrix, presented downstream with a valid/ready handshake.
module tpu_output_collector #(
    parameter  int N     = 3,
    parameter  int ACC_W = 24,
    localparam int RP_W  = $clog2(N + 1)
) (
    input  logic                                clk,
    input  logic                                nrst,
    input  logic [0:N-1][ACC_W-1:0]             col_data,
    input  logic [N-1:0]                        col_valid,
    input  logic                                out_ready,
    input  logic                                err_clr,
    output logic [0:N-1][0:N-1][ACC_W-1:0]      matrix_out,
    output logic                                out_valid,
    output logic                                col_busy,
    output logic                                overflow,
    output logic                                dbg_state,
    output logic [0:N-1][RP_W-1:0]              dbg_rp
);

    // Handshake: a matrix transfers on any cycle where out_valid && out_ready
    // are both high at the rising clk edge; matrix_out is stable while
    // out_valid=1 and out_ready=0, and out_ready is ignored while collecting.

    typedef enum logic {
        COLLECT = 1'b0,
        FULL    = 1'b1
    } state_t;

    state_t                  state, state_nx;
    logic [0:N-1][RP_W-1:0]  rp, rp_nx, wr_row;
    logic [N-1:0]            wr_en, drop;
    logic                    accept, all_full;

    always_comb begin
        state_nx = state;
        rp_nx    = rp;
        wr_row   = rp;
        wr_en    = '0;
        drop     = '0;
        all_full = 1'b1;
        accept   = (state == FULL) && out_ready;

        for (int j = 0; j < N; j++) begin
            if (state == COLLECT) begin
                if (col_valid[j]) begin
                    if (rp[j] < RP_W'(N)) begin
                        wr_en[j] = 1'b1;
                        rp_nx[j] = rp[j] + RP_W'(1);
                    end else begin
                        drop[j] = 1'b1;
                    end
                end
            end else if (accept) begin
                // A beat arriving with the acceptance starts the next matrix.
                rp_nx[j]  = '0;
                wr_row[j] = '0;
                if (col_valid[j]) begin
                    wr_en[j] = 1'b1;
                    rp_nx[j] = RP_W'(1);
                end
            end else if (col_valid[j]) begin
                drop[j] = 1'b1;
            end
        end

        for (int j = 0; j < N; j++) begin
            if (rp_nx[j] != RP_W'(N)) begin
                all_full = 1'b0;
            end
        end

        if ((state == COLLECT) || accept) begin
            state_nx = all_full ? FULL : COLLECT;
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state      <= COLLECT;
            rp         <= '0;
            overflow   <= 1'b0;
            matrix_out <= '0;
        end else begin
            state <= state_nx;
            rp    <= rp_nx;
            // A new drop wins over a simultaneous clear.
            if (|drop) begin
                overflow <= 1'b1;
            end else if (err_clr) begin
                overflow <= 1'b0;
            end
            for (int r = 0; r < N; r++) begin
                for (int j = 0; j < N; j++) begin
                    if (wr_en[j] && (wr_row[j] == RP_W'(r))) begin
                        matrix_out[r][j] <= col_data[j];
                    end
                end
            end
        end
    end

    assign out_valid = (state == FULL);
    assign col_busy  = (state == COLLECT) && (|rp);
    assign dbg_state = state;
    assign dbg_rp    = rp;

endmodule

// File: tb/tb_tpu_output_collector.sv
// Directed, table-driven bench for tpu_output_collector (N=3, ACC_W=24),
// plus hand-written sequences for accept-with-capture and skewed fills.
module tb_tpu_output_collector;

    localparam int N     = 3;
    localparam int ACC_W = 24;

    typedef logic [0:N-1][0:N-1][ACC_W-1:0] mat_t;

    typedef struct {
        logic        nrst;
        logic [2:0]  cv;
        int          d0, d1, d2;
        logic        rdy, clr;
        logic        ev, eb, eo;
        logic        chk;
        mat_t        em;
    } vec_t;

    logic                          clk = 1'b0;
    logic                          nrst;
    logic [0:N-1][ACC_W-1:0]       col_data;
    logic [N-1:0]                  col_valid;
    logic                          out_ready;
    logic                          err_clr;
    mat_t                          matrix_out;
    logic                          out_valid;
    logic                          col_busy;
    logic                          overflow;
    logic                          dbg_state;
    logic [0:N-1][1:0]             dbg_rp;

    int checks = 0;
    int errors = 0;
    vec_t vq[$];

    tpu_output_collector #(.N(N), .ACC_W(ACC_W)) dut (
        .clk        (clk),
        .nrst       (nrst),
        .col_data   (col_data),
        .col_valid  (col_valid),
        .out_ready  (out_ready),
        .err_clr    (err_clr),
        .matrix_out (matrix_out),
        .out_valid  (out_valid),
        .col_busy   (col_busy),
        .overflow   (overflow),
        .dbg_state  (dbg_state),
        .dbg_rp     (dbg_rp)
    );

    always #5 clk = ~clk;

    function automatic mat_t mk(int a, int b, int c, int d, int e, int f, int g, int h, int i);
        mat_t m;
        m[0][0] = 24'(a); m[0][1] = 24'(b); m[0][2] = 24'(c);
        m[1][0] = 24'(d); m[1][1] = 24'(e); m[1][2] = 24'(f);
        m[2][0] = 24'(g); m[2][1] = 24'(h); m[2][2] = 24'(i);
        return m;
    endfunction

    task automatic add(input logic n, input logic [2:0] cv, input int d0, input int d1,
                       input int d2, input logic rdy, input logic clr, input logic ev,
                       input logic eb, input logic eo, input logic chk, input mat_t em);
        vec_t v;
        v.nrst = n; v.cv = cv; v.d0 = d0; v.d1 = d1; v.d2 = d2;
        v.rdy = rdy; v.clr = clr; v.ev = ev; v.eb = eb; v.eo = eo;
        v.chk = chk; v.em = em;
        vq.push_back(v);
    endtask

    // Drive on the falling edge, then sample 1ns after the next rising edge.
    task automatic drive(input logic n, input logic [2:0] cv, input int d0, input int d1,
                         input int d2, input logic rdy, input logic clr);
        @(negedge clk);
        nrst        = n;
        col_valid   = cv;
        col_data[0] = 24'(d0);
        col_data[1] = 24'(d1);
        col_data[2] = 24'(d2);
        out_ready   = rdy;
        err_clr     = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string name, input logic [ACC_W-1:0] act, input logic [ACC_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_mat(input string name, input mat_t exp);
        checks++;
        if (matrix_out !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, matrix_out, exp);
        end
    endtask

    initial begin
        mat_t z, m1, m2;
        int   cyc;

        nrst = 1'b0; col_valid = '0; col_data = '0; out_ready = 1'b0; err_clr = 1'b0;
        z  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
        m1 = mk(1, 2, 3, 4, 5, 6, 7, 8, 9);
        m2 = mk(10, 11, 12, 13, 14, 15, 16, 17, 18);

        // reset
        add(0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 1, z);
        // skewed fill: column j presents rows on t0+j..t0+j+2
        add(1, 3'b001, 1, 0, 0, 0, 0, 0, 1, 0, 0, z);
        add(1, 3'b011, 4, 2, 0, 0, 0, 0, 1, 0, 0, z);
        add(1, 3'b111, 7, 5, 3, 0, 0, 0, 1, 0, 0, z);
        add(1, 3'b110, 0, 8, 6, 0, 0, 0, 1, 0, 0, z);
        add(1, 3'b100, 0, 0, 9, 0, 0, 1, 0, 0, 1, m1);
        // backpressure hold; a stray column-0 beat of 99 is dropped
        for (int k = 0; k < 10; k++)
            add(1, (k == 4) ? 3'b001 : 3'b000, (k == 4) ? 99 : 0, 0, 0, 0, 0,
                1, 0, (k >= 4), 1, m1);
        // err_clr alone, err_clr with a drop, err_clr alone
        add(1, 3'b000, 0, 0, 0, 0, 1, 1, 0, 0, 1, m1);
        add(1, 3'b010, 0, 77, 0, 0, 1, 1, 0, 1, 1, m1);
        add(1, 3'b000, 0, 0, 0, 0, 1, 1, 0, 0, 1, m1);
        // accept while column 0 presents 10; out_ready high in COLLECT is ignored
        add(1, 3'b001, 10, 0, 0, 1, 0, 0, 1, 0, 1, mk(10, 2, 3, 4, 5, 6, 7, 8, 9));
        add(1, 3'b011, 13, 11, 0, 1, 0, 0, 1, 0, 0, z);
        add(1, 3'b111, 16, 14, 12, 1, 0, 0, 1, 0, 0, z);
        add(1, 3'b110, 0, 17, 15, 1, 0, 0, 1, 0, 0, z);
        add(1, 3'b100, 0, 0, 18, 0, 0, 1, 0, 0, 1, m2);
        // accept on the first FULL cycle with nothing arriving
        add(1, 3'b000, 0, 0, 0, 1, 0, 0, 0, 0, 1, m2);
        // uneven skew: column 2 completes first, then an extra column-2 beat
        add(1, 3'b100, 0, 0, 20, 0, 0, 0, 1, 0, 0, z);
        add(1, 3'b100, 0, 0, 21, 0, 0, 0, 1, 0, 0, z);
        add(1, 3'b100, 0, 0, 22, 0, 0, 0, 1, 0, 0, z);
        add(1, 3'b100, 0, 0, 99, 0, 0, 0, 1, 1, 1, mk(10, 11, 20, 13, 14, 21, 16, 17, 22));
        add(1, 3'b011, 30, 40, 0, 0, 0, 0, 1, 1, 0, z);
        add(1, 3'b011, 31, 41, 0, 0, 0, 0, 1, 1, 0, z);
        add(1, 3'b011, 32, 42, 0, 0, 0, 1, 0, 1, 1, mk(30, 40, 20, 31, 41, 21, 32, 42, 22));
        add(1, 3'b000, 0, 0, 0, 1, 1, 0, 0, 0, 0, z);
        // reset mid-collection after 4 beats, then a full fill
        add(1, 3'b111, 1, 2, 3, 0, 0, 0, 1, 0, 0, z);
        add(1, 3'b001, 4, 0, 0, 0, 0, 0, 1, 0, 1, mk(1, 2, 3, 4, 41, 21, 32, 42, 22));
        add(0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 1, z);
        add(1, 3'b111, 50, 51, 52, 0, 0, 0, 1, 0, 0, z);
        add(1, 3'b111, 53, 54, 55, 0, 0, 0, 1, 0, 0, z);
        add(1, 3'b111, 56, 57, 58, 0, 0, 1, 0, 0, 1, mk(50, 51, 52, 53, 54, 55, 56, 57, 58));

        foreach (vq[i]) begin
            drive(vq[i].nrst, vq[i].cv, vq[i].d0, vq[i].d1, vq[i].d2, vq[i].rdy, vq[i].clr);
            chk1($sformatf("v%0d out_valid", i), 24'(out_valid), 24'(vq[i].ev));
            chk1($sformatf("v%0d col_busy", i), 24'(col_busy), 24'(vq[i].eb));
            chk1($sformatf("v%0d overflow", i), 24'(overflow), 24'(vq[i].eo));
            if (vq[i].chk) chk_mat($sformatf("v%0d matrix", i), vq[i].em);
        end

        // accept with capture into row 0; untouched cells keep the old matrix
        drive(1, 3'b001, 60, 0, 0, 1, 0);
        chk1("acc state", 24'(dbg_state), 24'd0);
        chk1("acc rp0", 24'(dbg_rp[0]), 24'd1);
        chk1("acc rp1", 24'(dbg_rp[1]), 24'd0);
        chk1("acc m00", matrix_out[0][0], 24'd60);
        chk1("acc m11", matrix_out[1][1], 24'd54);
        chk1("acc overflow", 24'(overflow), 24'd0);

        // column 2 then column 1 then column 0 with gaps
        for (int k = 0; k < 3; k++) drive(1, 3'b100, 0, 0, 70 + k, 0, 0);
        for (int k = 0; k < 3; k++) drive(1, 3'b010, 0, 80 + k, 0, 0, 0);
        drive(1, 3'b001, 61, 0, 0, 1, 0);
        drive(1, 3'b000, 0, 0, 0, 1, 0);
        chk1("gap busy", 24'(col_busy), 24'd1);
        drive(1, 3'b001, 62, 0, 0, 0, 0);
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            drive(1, 3'b000, 0, 0, 0, 0, 0);
            cyc++;
        end
        chk1("skew wait out_valid", 24'(out_valid), 24'd1);
        chk_mat("skew matrix", mk(60, 80, 70, 61, 81, 71, 62, 82, 72));
        chk1("skew overflow", 24'(overflow), 24'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
